reg_access_ctrl: RTL

//   Upstream access controller for the 16x32 register file (REG_32).
//   - Merges a write channel and a read-request channel into one stream of register-file strobes.
//   - Never asserts rf_read_en and rf_write_en together.
//   - Tracks the register file's 1-cycle read latency and returns read data on a backpressured response channel.

---
 rtl/reg_access_ctrl_if.sv | 46 ++++
 rtl/reg_access_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl_if.sv
// Bus bundle between the access controller, its requesters/consumer and the 16x32 register file.
// The slave modport is the controller's view; master is the surrounding system's view.
interface reg_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;

    logic              rf_read_en;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_read_data;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr,
        input  rsp_ready,
        input  rf_read_data,
        output wr_ready, rd_ready,
        output rsp_valid, rsp_data, rsp_addr,
        output rf_read_en, rf_write_en, rf_addr, rf_write_data
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr,
        output rsp_ready,
        output rf_read_data,
        input  wr_ready, rd_ready,
        input  rsp_valid, rsp_data, rsp_addr,
        input  rf_read_en, rf_write_en, rf_addr, rf_write_data
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Round-robin merge of write and read-request channels onto the register file strobes,
// with a credit-guarded response FIFO covering the register file's 1-cycle read latency.
module reg_access_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int RSP_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    reg_access_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    logic              rf_read_en_q,    rf_read_en_d;
    logic              rf_write_en_q,   rf_write_en_d;
    logic [ADDR_W-1:0] rf_addr_q,       rf_addr_d;
    logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
    logic              s2_valid_q,      s2_valid_d;
    logic [ADDR_W-1:0] s2_addr_q,       s2_addr_d;
    logic              last_grant_q,    last_grant_d;

    logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [RSP_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [RSP_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic [1:0]        inflight;
    logic [OCC_W-1:0]  occupancy;
    logic              rd_ok;
    logic              wr_req;
    logic              rd_req;
    logic              grant_wr;
    logic              grant_rd;
    logic              rsp_valid;
    logic              push;
    logic              pop;

    // A read is only admitted if a FIFO slot is guaranteed for it once it leaves the pipeline.
    always_comb begin
        inflight  = {1'b0, rf_read_en_q} + {1'b0, s2_valid_q};
        occupancy = OCC_W'(count_q) + OCC_W'(inflight);
        rd_ok     = occupancy < OCC_W'(RSP_DEPTH);
        wr_req    = bus.wr_valid && !rst;
        rd_req    = bus.rd_valid && rd_ok && !rst;
    end

    always_comb begin
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        last_grant_d = last_grant_q;
        if (wr_req && rd_req) begin
            if (last_grant_q == GRANT_WR) begin
                grant_rd     = 1'b1;
                last_grant_d = GRANT_RD;
            end else begin
                grant_wr     = 1'b1;
                last_grant_d = GRANT_WR;
            end
        end else if (wr_req) begin
            grant_wr = 1'b1;
        end else if (rd_req) begin
            grant_rd = 1'b1;
        end
    end

    always_comb begin
        rf_write_en_d   = grant_wr;
        rf_read_en_d    = grant_rd;
        rf_addr_d       = rf_addr_q;
        rf_write_data_d = rf_write_data_q;
        if (grant_wr) begin
            rf_addr_d       = bus.wr_addr;
            rf_write_data_d = bus.wr_data;
        end else if (grant_rd) begin
            rf_addr_d       = bus.rd_addr;
        end
        s2_valid_d = rf_read_en_q;
        s2_addr_d  = rf_addr_q;
    end

    // The S2 stage is the cycle in which rf_read_data holds the word addressed in S1.
    always_comb begin
        rsp_valid   = (count_q != '0) && !rst;
        push        = s2_valid_q;
        pop         = rsp_valid && bus.rsp_ready;
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = bus.rf_read_data;
            fifo_addr_d[wr_ptr_q] = s2_addr_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_read_en_q    <= 1'b0;
            rf_write_en_q   <= 1'b0;
            rf_addr_q       <= '0;
            rf_write_data_q <= '0;
            s2_valid_q      <= 1'b0;
            s2_addr_q       <= '0;
            last_grant_q    <= GRANT_WR;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            rf_read_en_q    <= rf_read_en_d;
            rf_write_en_q   <= rf_write_en_d;
            rf_addr_q       <= rf_addr_d;
            rf_write_data_q <= rf_write_data_d;
            s2_valid_q      <= s2_valid_d;
            s2_addr_q       <= s2_addr_d;
            last_grant_q    <= last_grant_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            fifo_data_q     <= fifo_data_d;
            fifo_addr_q     <= fifo_addr_d;
        end
    end

    assign bus.wr_ready      = grant_wr;
    assign bus.rd_ready      = grant_rd;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_data      = fifo_data_q[rd_ptr_q];
    assign bus.rsp_addr      = fifo_addr_q[rd_ptr_q];
    assign bus.rf_read_en    = rf_read_en_q;
    assign bus.rf_write_en   = rf_write_en_q;
    assign bus.rf_addr       = rf_addr_q;
    assign bus.rf_write_data = rf_write_data_q;
endmodule
